// File: rtl/proc_run_ctrl_if.sv
// Image-stream and instruction-memory write port bundle for proc_run_ctrl.
// The slave modport is the controller's view; master is the environment's view.
interface proc_run_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport slave (
    input  src_valid, src_data,
    output src_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output src_valid, src_data,
    input  src_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/proc_run_ctrl.sv
// Run controller: streams a program image into instruction memory, holds the
// core in reset while loading, then runs it until halt or cycle-limit timeout.
module proc_run_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic [ADDR_W-1:0] img_len,
  input  logic [CNT_W-1:0]  cycle_limit,
  proc_run_ctrl_if.slave    bus,
  output logic              cpu_rst_n,
  output logic [ADDR_W-1:0] cpu_pc,
  input  logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycles
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_start_pc;
  logic [ADDR_W-1:0]   r_img_len;
  logic [CNT_W-1:0]    r_limit;
  logic [ADDR_W-1:0]   r_load_cnt;
  logic [CNT_W-1:0]    r_cycles;
  logic                r_done;
  logic                r_timeout;

  logic w_load;
  logic w_run;
  logic w_start_ok;
  logic w_hs;
  logic w_last;
  logic w_limit_hit;

  assign w_load      = (r_state == S_LOAD);
  assign w_run       = (r_state == S_RUN);
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_hs        = w_load && bus.src_valid;
  assign w_last      = w_hs && (r_load_cnt == r_img_len - ADDR_W'(1));
  // Limit is compared against the pre-increment count so the run lasts exactly M cycles.
  assign w_limit_hit = w_run && (r_limit != '0) && (r_cycles == r_limit - CNT_W'(1));

  // NOTE: next-state defaults to the current state before the case, so no latch is inferred.
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) w_next = (img_len != '0) ? S_LOAD : S_RELEASE;
        S_LOAD:         if (w_last) w_next = S_RELEASE;
        S_RELEASE:      w_next = S_RUN;
        S_RUN:          if (cpu_halt || w_limit_hit) w_next = S_DONE;
        default:        w_next = S_IDLE;
      endcase
    end
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_pc <= '0;
      r_img_len  <= '0;
      r_limit    <= '0;
      r_load_cnt <= '0;
      r_cycles   <= '0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (abort) begin
      r_load_cnt <= '0;
      r_cycles   <= '0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (w_start_ok) begin
      r_start_pc <= start_pc;
      r_img_len  <= img_len;
      r_limit    <= cycle_limit;
      r_load_cnt <= '0;
      r_cycles   <= '0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_hs) r_load_cnt <= r_load_cnt + ADDR_W'(1);
      if (w_run) begin
        if (r_cycles != '1) r_cycles <= r_cycles + CNT_W'(1);
        if (cpu_halt) begin
          r_done    <= 1'b1;
          r_timeout <= 1'b0;
        end else if (w_limit_hit) begin
          r_done    <= 1'b1;
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign bus.src_ready = w_load;
  assign bus.mem_we    = w_hs;
  assign bus.mem_addr  = r_load_cnt;
  // Write data is gated so the port is quiet (zero) outside LOAD, including in reset.
  assign bus.mem_wdata = w_load ? bus.src_data : '0;

  assign cpu_rst_n = w_run;
  assign cpu_pc    = r_start_pc;
  assign busy      = (r_state == S_LOAD) || (r_state == S_RELEASE) || w_run;
  assign done      = r_done;
  assign timeout   = r_timeout;
  assign cycles    = r_cycles;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl: table-driven load vectors plus hand-written
// run, timeout, abort and reset sequences.
module tb_proc_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] start_pc;
  logic [15:0] img_len;
  logic [15:0] cycle_limit;
  logic        cpu_rst_n;
  logic [15:0] cpu_pc;
  logic        cpu_halt;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] cycles;

  proc_run_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  proc_run_ctrl #(.ADDR_W(16), .DATA_W(16), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .start_pc    (start_pc),
    .img_len     (img_len),
    .cycle_limit (cycle_limit),
    .bus         (bus.slave),
    .cpu_rst_n   (cpu_rst_n),
    .cpu_pc      (cpu_pc),
    .cpu_halt    (cpu_halt),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .cycles      (cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        rdy;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        crst;
  } vec_t;

  vec_t vecs [15];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] pc, input logic [15:0] len, input logic [15:0] lim);
    start = 1'b1; start_pc = pc; img_len = len; cycle_limit = lim;
    step();
    start = 1'b0;
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.src_valid = vecs[i].v;
      bus.src_data  = vecs[i].d;
      #1;
      check($sformatf("row%0d", i),
            64'({bus.src_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy, cpu_rst_n}),
            64'({vecs[i].rdy, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].busy, vecs[i].crst}));
      step();
    end
  endtask

  // Steps until done rises or the budget expires; counts cycles seen in RUN.
  task automatic run_until_done(input int budget, output int n_run);
    n_run = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      if (cpu_rst_n) n_run++;
      step();
    end
    check("run_bound", 64'(done), 64'(1));
  endtask

  initial begin
    int n_run;
    int n_we;

    // Load with src_valid held high: 4 writes, RELEASE, then RUN.
    vecs[0]  = '{1'b1, 16'h1111, 1'b1, 1'b1, 16'd0, 16'h1111, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 16'h2222, 1'b1, 1'b1, 16'd1, 16'h2222, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 16'h3333, 1'b1, 1'b1, 16'd2, 16'h3333, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 16'h4444, 1'b1, 1'b1, 16'd3, 16'h4444, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'd4, 16'h0000, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'd4, 16'h0000, 1'b1, 1'b1};
    // Same image with src_valid toggling: no write on gap cycles.
    vecs[6]  = '{1'b1, 16'h1111, 1'b1, 1'b1, 16'd0, 16'h1111, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 16'hAAAA, 1'b1, 1'b0, 16'd1, 16'hAAAA, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 16'h2222, 1'b1, 1'b1, 16'd1, 16'h2222, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 16'hAAAA, 1'b1, 1'b0, 16'd2, 16'hAAAA, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 16'h3333, 1'b1, 1'b1, 16'd2, 16'h3333, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 16'hAAAA, 1'b1, 1'b0, 16'd3, 16'hAAAA, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 16'h4444, 1'b1, 1'b1, 16'd3, 16'h4444, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 16'h5555, 1'b0, 1'b0, 16'd4, 16'h0000, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'd4, 16'h0000, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cpu_halt = 1'b0;
    start_pc = '0; img_len = '0; cycle_limit = '0;
    bus.src_valid = 1'b1; bus.src_data = 16'hABCD;
    #12;
    check("reset_outs",
          64'({bus.src_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_rst_n, cpu_pc,
               busy, done, timeout, cycles}),
          64'(0));
    step();
    rst_n = 1'b1;
    bus.src_valid = 1'b0;
    step();
    check("idle_busy", 64'(busy), 64'(0));

    // Full-rate load, cpu_rst_n rises 6 edges after the start pulse.
    do_start(16'h0010, 16'd4, 16'd0);
    apply_rows(0, 5);
    check("t1_pc", 64'(cpu_pc), 64'h0010);
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    check("t1_done", 64'({done, timeout, cycles, cpu_rst_n, busy}), 64'({1'b1, 1'b0, 16'd2, 1'b0, 1'b0}));

    // Gapped load, then abort out of RUN.
    do_start(16'h0010, 16'd4, 16'd0);
    check("t2_clr_done", 64'(done), 64'(0));
    apply_rows(6, 14);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t2_abort", 64'({busy, cpu_rst_n, done, cycles}), 64'(0));

    // No load, halt on the 5th RUN cycle.
    do_start(16'h0020, 16'd0, 16'd0);
    check("t3_release", 64'({busy, cpu_rst_n, cpu_pc}), 64'({1'b1, 1'b0, 16'h0020}));
    step();
    check("t3_run1", 64'({cpu_rst_n, cycles}), 64'({1'b1, 16'd0}));
    repeat (4) step();
    check("t3_run5", 64'(cycles), 64'(4));
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    check("t3_done", 64'({done, timeout, cycles, cpu_rst_n}), 64'({1'b1, 1'b0, 16'd5, 1'b0}));
    cpu_halt = 1'b1;
    repeat (3) step();
    cpu_halt = 1'b0;
    check("t3_sticky", 64'({done, timeout, cycles, cpu_pc}), 64'({1'b1, 1'b0, 16'd5, 16'h0020}));

    // Timeout after exactly 10 RUN cycles.
    do_start(16'h0000, 16'd0, 16'd10);
    run_until_done(40, n_run);
    check("t4_run_cycles", 64'(n_run), 64'(10));
    check("t4_timeout", 64'({done, timeout, cycles}), 64'({1'b1, 1'b1, 16'd10}));

    // Halt coincident with limit: halt wins.
    do_start(16'h0000, 16'd0, 16'd3);
    check("t4b_clr", 64'({done, timeout}), 64'(0));
    repeat (3) step();
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    check("t4b_halt_wins", 64'({done, timeout, cycles}), 64'({1'b1, 1'b0, 16'd3}));

    // Abort during LOAD after 2 of 4 words; a start in the same cycle loses.
    bus.src_valid = 1'b1; bus.src_data = 16'h7777;
    do_start(16'h0030, 16'd4, 16'd0);
    step();
    step();
    check("t5_addr2", 64'(bus.mem_addr), 64'(2));
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    check("t5_abort", 64'({busy, bus.src_ready, bus.mem_we, done, cycles, cpu_rst_n}), 64'(0));
    n_we = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.mem_we) n_we++;
      step();
    end
    check("t5_no_writes", 64'(n_we), 64'(0));
    bus.src_valid = 1'b0;

    // Start pulse during RUN is ignored; original limit of 5 still applies.
    do_start(16'h0040, 16'd0, 16'd5);
    step();
    start = 1'b1; start_pc = 16'h0099; img_len = 16'd3; cycle_limit = 16'd2;
    step();
    start = 1'b0;
    check("t5_ignore", 64'({cpu_pc, busy, cpu_rst_n}), 64'({16'h0040, 1'b1, 1'b1}));
    run_until_done(40, n_run);
    check("t5_orig_limit", 64'({timeout, cycles, cpu_pc}), 64'({1'b1, 16'd5, 16'h0040}));

    // Asynchronous reset mid-RUN, then a fresh run.
    do_start(16'h0050, 16'd0, 16'd0);
    repeat (3) step();
    bus.src_valid = 1'b1; bus.src_data = 16'hBEEF;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async",
          64'({bus.src_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_rst_n, cpu_pc,
               busy, done, timeout, cycles}),
          64'(0));
    step();
    rst_n = 1'b1;
    do_start(16'h0060, 16'd1, 16'd0);
    #1;
    check("t6_write", 64'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'({1'b1, 16'd0, 16'hBEEF}));
    step();
    bus.src_valid = 1'b0;
    check("t6_release", 64'({busy, cpu_rst_n, bus.src_ready}), 64'({1'b1, 1'b0, 1'b0}));
    step();
    check("t6_run", 64'({cpu_rst_n, cpu_pc}), 64'({1'b1, 16'h0060}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
